// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier (MUL / UMULL / SMULL) with its
// own sequencing FSM. Fixed latency of WIDTH+2 cycles from Start to Done.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for Start; operands latched on the accepting edge
//   RUN    | one multiplier bit per cycle, LSB first (WIDTH cycles)
//   FIX    | apply sign, mask high half for MUL, compute {N,Z}
//   DONE   | Done pulse; results already registered; back to IDLE
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 is_mul_q, is_mul_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;
  logic [1:0]           flags_q, flags_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   prod;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    is_mul_d  = is_mul_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    flags_d   = flags_q;

    // Magnitudes: -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    is_signed = (MulOp == 2'b10);
    abs_a     = SrcA[WIDTH-1] ? -SrcA : SrcA;
    abs_b     = SrcB[WIDTH-1] ? -SrcB : SrcB;
    prod      = neg_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = {{WIDTH{1'b0}}, (is_signed ? abs_a : SrcA)};
          mplier_d = is_signed ? abs_b : SrcB;
          neg_d    = is_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          is_mul_d = !((MulOp == 2'b01) || (MulOp == 2'b10));
          acc_d    = '0;
          cnt_d    = CNT_LAST;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Multiplicand is pre-shifted each cycle, so it always sits at the iteration index.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        res_lo_d = prod[WIDTH-1:0];
        if (is_mul_q) begin
          res_hi_d = '0;
          flags_d  = {prod[WIDTH-1], (prod[WIDTH-1:0] == '0)};
        end else begin
          res_hi_d = prod[2*WIDTH-1:WIDTH];
          flags_d  = {prod[2*WIDTH-1], (prod == '0)};
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      is_mul_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      is_mul_q <= is_mul_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign ResultLo = res_lo_q;
  assign ResultHi = res_hi_q;
  assign MulFlags = flags_q;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply unit with its own sequencing FSM, started by the multi-cycle controller when it decodes a multiply (`opMul`). It computes the three multiply forms: MUL (low 32 bits), UMULL and SMULL (64-bit results). The controller holds its main FSM in an execute-wait state while `Busy` is high. It writes `ResultLo`/`ResultHi` back through the normal result path once `Done` pulses.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; the product is 2*`WIDTH` bits.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high; overrides every other input.
- `Start`  in  1  — request a multiply; sampled only in IDLE.
- `MulOp`  in  2  — operation select: 00 MUL, 01 UMULL, 10 SMULL; 11 is treated as MUL.
- `SrcA`  in  `WIDTH`  — multiplicand (Rn/Rm per decode).
- `SrcB`  in  `WIDTH`  — multiplier.
- `Busy`  out  1  — high in RUN and FIX.
- `Done`  out  1  — one-cycle pulse in DONE.
- `ResultLo`  out  `WIDTH`  — low half of the product.
- `ResultHi`  out  `WIDTH`  — high half of the product; 0 for MUL.
- `MulFlags`  out  2  — {N, Z} for flag-setting multiplies.

## Operation
- **States:** IDLE, RUN, FIX, DONE. Reset enters IDLE.
- **IDLE:**
  - If `Start`=1, latch `SrcA`, `SrcB` and `MulOp`, then go to RUN.
  - For SMULL, latch the magnitudes |A| and |B| and record `neg` = A[msb] XOR B[msb]. |−2^(WIDTH−1)| is taken as the unsigned value 2^(WIDTH−1).
  - For MUL and UMULL, latch the operands unchanged and set `neg`=0.
  - Clear the 2*`WIDTH` accumulator and load the iteration counter with `WIDTH`−1.
- **RUN:** one multiplier bit per cycle, LSB first.
  - If the current multiplier bit is 1, add the multiplicand, shifted by the iteration index, to the accumulator (2*`WIDTH`-bit add, no overflow possible).
  - Decrement the counter.
  - After `WIDTH` RUN cycles, go to FIX.
- **FIX:**
  - If `neg`=1, replace the accumulator with its 2*`WIDTH`-bit two's complement.
  - For MUL, zero the high half.
  - Compute the flags:
    - MUL: N = product[`WIDTH`−1], Z = (low half == 0).
    - Long forms: N = product[2*`WIDTH`−1], Z = (full 64 bits == 0).
  - Go to DONE.
- **DONE:**
  - `Done`=1 for exactly this cycle.
  - Return to IDLE unconditionally. A `Start` asserted in the DONE cycle is ignored.
- **Result retention:** `ResultLo`, `ResultHi` and `MulFlags` update only on the FIX→DONE edge. They hold until the next completed operation, so they remain valid in IDLE after `Done`.
- **Busy behaviour:** `Start` is ignored while `Busy`=1. Operand and `MulOp` changes during RUN have no effect.
- **Reset mid-operation:** returns to IDLE on the next edge, discards the accumulator, and zeroes all outputs.

## Timing
- **Reset values:** state IDLE; `Busy`=0, `Done`=0, `ResultLo`=0, `ResultHi`=0, `MulFlags`=00.
- **Fixed latency, independent of operand values:**
  - `Start` sampled at edge t.
  - `Busy`=1 during cycles t+1 … t+`WIDTH`+1 (`WIDTH` RUN cycles plus one FIX cycle).
  - `Done`=1 in cycle t+`WIDTH`+2; 34 for `WIDTH`=32.
- **Back-to-back:** the earliest next `Start` accepted is in the cycle after DONE, i.e. IDLE at t+`WIDTH`+3.
- **Outputs:** all outputs are registered; there is no combinational path from any input to any output.
- **Controller handshake:**
  - The controller asserts `Start` for one cycle in its execute state.
  - It waits while `Busy`=1 or until `Done`.
  - It asserts RegWrite for the result in the `Done` cycle or later.

## Test plan
- **MUL:** reset 2 cycles, then MUL with `SrcA`=7, `SrcB`=6 → `Busy` high for 33 cycles, `Done` pulse 34 cycles after `Start`, `ResultLo`=0x0000002A, `ResultHi`=0, `MulFlags`=00.
- **UMULL:** `SrcA`=`SrcB`=0xFFFFFFFF → `ResultHi`=0xFFFFFFFE, `ResultLo`=0x00000001, N=1, Z=0.
- **SMULL:** `SrcA`=0xFFFFFFFF (−1), `SrcB`=2 → `ResultHi`=0xFFFFFFFF, `ResultLo`=0xFFFFFFFE, N=1. Then `SrcA`=`SrcB`=0x80000000 → `ResultHi`=0x40000000, `ResultLo`=0, N=0, Z=0.
- **Zero and ignored inputs:** MUL 0x12345678 × 0 → results 0, Z=1. `MulOp`=11 behaves as MUL. MUL 0x10000 × 0x10000 → `ResultLo`=0, `ResultHi`=0, Z=1.
- **`Start` while busy:** `Start` with new operands at cycle t+5 and again in the DONE cycle → both ignored; first result unchanged and a single `Done` pulse. `Start` at t+`WIDTH`+3 is accepted normally.
- **Reset mid-operation:** assert `reset` at cycle t+10 → next cycle IDLE, all outputs zero, no `Done` pulse. A fresh MUL 3×5 afterwards completes with `ResultLo`=15 at the nominal latency.
